// File: rtl/legv8_multicycle_control.sv
// Multi-cycle LEGv8 control unit: fetches the instruction at pc, decodes a fixed
// subset and sequences the datapath control word and immediate state by state.
module legv8_multicycle_control #(
  parameter logic [63:0] PC_RESET = 64'd0,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] instruction,
  input  logic [3:0]  status,
  output logic [63:0] pc,
  output logic [24:0] control_word,
  output logic [63:0] constant,
  output logic        halted
);

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEMRD, S_WB, S_HALT} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI,
    OP_LDUR, OP_STUR, OP_CBZ, OP_B, OP_UNDEF
  } op_t;

  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  op_t         op;

  logic        mem_write, reg_write, bsel, en_mem, en_alu;
  logic [4:0]  sa, sb, da, fs;
  logic [63:0] const_d;

  logic [4:0]  rm, rn, rd;
  logic [63:0] imm12_z, imm9_s, off19, off26;
  logic        status_unused;

  assign rm      = ir_q[20:16];
  assign rn      = ir_q[9:5];
  assign rd      = ir_q[4:0];
  assign imm12_z = {52'd0, ir_q[21:10]};
  assign imm9_s  = {{55{ir_q[20]}}, ir_q[20:12]};
  assign off19   = {{43{ir_q[23]}}, ir_q[23:5], 2'b00};
  assign off26   = {{36{ir_q[25]}}, ir_q[25:0], 2'b00};
  assign status_unused = ^status[3:1];

  // Shortest opcode wins: B, then CBZ, then 10-bit, then 11-bit patterns.
  always_comb begin
    op = OP_UNDEF;
    if (ir_q[31:26] == 6'b000101)             op = OP_B;
    else if (ir_q[31:24] == 8'b10110100)      op = OP_CBZ;
    else if (ir_q[31:22] == 10'b1001000100)   op = OP_ADDI;
    else if (ir_q[31:22] == 10'b1101000100)   op = OP_SUBI;
    else begin
      case (ir_q[31:21])
        11'b10001011000: op = OP_ADD;
        11'b11001011000: op = OP_SUB;
        11'b10001010000: op = OP_AND;
        11'b10101010000: op = OP_ORR;
        11'b11111000010: op = OP_LDUR;
        11'b11111000000: op = OP_STUR;
        default:         op = OP_UNDEF;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mem_write = 1'b0;
    reg_write = 1'b0;
    bsel      = 1'b0;
    en_mem    = 1'b0;
    en_alu    = 1'b0;
    sa        = '0;
    sb        = '0;
    da        = '0;
    fs        = '0;
    const_d   = '0;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_d    = instruction;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
            sa        = rn;
            sb        = rm;
            da        = rd;
            reg_write = 1'b1;
            en_alu    = 1'b1;
            fs        = (op == OP_ADD) ? FS_ADD :
                        (op == OP_SUB) ? FS_SUB :
                        (op == OP_AND) ? FS_AND : FS_ORR;
            pc_d      = pc_q + PC_STEP;
          end
          OP_ADDI, OP_SUBI: begin
            sa        = rn;
            da        = rd;
            reg_write = 1'b1;
            en_alu    = 1'b1;
            bsel      = 1'b1;
            const_d   = imm12_z;
            fs        = (op == OP_ADDI) ? FS_ADD : FS_SUB;
            pc_d      = pc_q + PC_STEP;
          end
          OP_LDUR: begin
            sa      = rn;
            bsel    = 1'b1;
            const_d = imm9_s;
            fs      = FS_ADD;
            state_d = S_MEMRD;
          end
          OP_STUR: begin
            sa        = rn;
            sb        = rd;
            bsel      = 1'b1;
            const_d   = imm9_s;
            fs        = FS_ADD;
            mem_write = 1'b1;
            pc_d      = pc_q + PC_STEP;
          end
          OP_CBZ: begin
            sa   = rd;
            bsel = 1'b1;
            fs   = FS_ADD;
            pc_d = status[0] ? pc_q + off19 : pc_q + PC_STEP;
          end
          OP_B: pc_d = pc_q + off26;
          default: state_d = S_HALT;
        endcase
      end
      // IR is necessarily LDUR in MEMRD/WB, so its address fields are simply held.
      S_MEMRD, S_WB: begin
        sa      = rn;
        bsel    = 1'b1;
        const_d = imm9_s;
        fs      = FS_ADD;
        if (state_q == S_MEMRD) begin
          state_d = S_WB;
        end else begin
          da        = rd;
          reg_write = 1'b1;
          en_mem    = 1'b1;
          pc_d      = pc_q + PC_STEP;
          state_d   = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign pc           = pc_q;
  assign control_word = {mem_write, sa, sb, da, reg_write, fs, bsel, en_mem, en_alu};
  assign constant     = const_d;
  assign halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Directed bench for legv8_multicycle_control: expected per-cycle outputs are
// queued as each step is driven and compared when that cycle is sampled.
module tb_legv8_multicycle_control;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [31:0] instruction;
  logic [3:0]  status;
  logic [63:0] pc;
  logic [24:0] control_word;
  logic [63:0] constant;
  logic        halted;

  legv8_multicycle_control #(
    .PC_RESET(64'd0),
    .PC_STEP (64'd4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .instruction (instruction),
    .status      (status),
    .pc          (pc),
    .control_word(control_word),
    .constant    (constant),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [24:0] ALL   = 25'h1FF_FFFF;

  typedef struct {
    string       tag;
    logic [24:0] cw;
    logic [24:0] mask;
    logic [63:0] k;
    logic [63:0] pcv;
    logic        h;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [24:0] mk_cw(input logic mw, input logic [4:0] a, input logic [4:0] b,
                                        input logic [4:0] d, input logic rw, input logic [4:0] f,
                                        input logic bs, input logic em, input logic ea);
    return {mw, a, b, d, rw, f, bs, em, ea};
  endfunction

  task automatic push_exp(input string tag, input logic [24:0] cw, input logic [24:0] mask,
                          input logic [63:0] k, input logic [63:0] pcv, input logic h);
    exp_t e;
    e.tag = tag; e.cw = cw; e.mask = mask; e.k = k; e.pcv = pcv; e.h = h;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    n_tests++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_tests += 3;
      assert ((control_word & e.mask) === (e.cw & e.mask)) else begin
        n_fail++;
        $error("FAIL %s control_word observed=%h expected=%h", e.tag, control_word & e.mask, e.cw & e.mask);
      end
      assert (constant === e.k) else begin
        n_fail++;
        $error("FAIL %s constant observed=%h expected=%h", e.tag, constant, e.k);
      end
      assert (pc === e.pcv) else begin
        n_fail++;
        $error("FAIL %s pc observed=%h expected=%h", e.tag, pc, e.pcv);
      end
      assert (halted === e.h) else begin
        n_fail++;
        $error("FAIL %s halted observed=%b expected=%b", e.tag, halted, e.h);
      end
    end
  endtask

  task automatic now_chk(input string tag, input logic [24:0] cw, input logic [63:0] k,
                         input logic [63:0] pcv, input logic h);
    push_exp(tag, cw, ALL, k, pcv, h);
    pop_cmp();
  endtask

  task automatic cyc(input string tag, input logic [24:0] cw, input logic [24:0] mask,
                     input logic [63:0] k, input logic [63:0] pcv, input logic h);
    push_exp(tag, cw, mask, k, pcv, h);
    @(negedge clock);
    pop_cmp();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] i_add, i_subi, i_ldur, i_stur, i_cbz, i_bm2, i_bp6, i_bm3;
  logic [24:0] cw_ld, cw_cbz;
  logic [24:0] no_sb;

  initial begin
    i_add  = 32'h8B02_0023;
    i_subi = {10'b1101000100, 12'd7, 5'd5, 5'd5};
    i_ldur = {11'b11111000010, 9'h1F8, 2'b00, 5'd2, 5'd9};
    i_stur = {11'b11111000000, 9'd16, 2'b00, 5'd6, 5'd4};
    i_cbz  = {8'b10110100, 19'd3, 5'd1};
    i_bm2  = {6'b000101, 26'h3FF_FFFE};
    i_bp6  = {6'b000101, 26'd6};
    i_bm3  = {6'b000101, 26'h3FF_FFFD};
    cw_ld  = mk_cw(1'b0, 5'd2, 5'd0, 5'd0, 1'b0, FS_ADD, 1'b1, 1'b0, 1'b0);
    cw_cbz = mk_cw(1'b0, 5'd1, 5'd0, 5'd0, 1'b0, FS_ADD, 1'b1, 1'b0, 1'b0);
    no_sb  = ALL & ~(25'd31 << 14);

    reset = 1'b0; run = 1'b0; instruction = '0; status = '0;
    #2 reset = 1'b1;
    #1 now_chk("reset_async", '0, '0, 64'd0, 1'b0);
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;

    run = 1'b1; instruction = i_add;
    cyc("add_fetch", '0, ALL, '0, 64'd0, 1'b0);
    instruction = 32'hFFFF_FFFF;
    cyc("add_exec", mk_cw(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, FS_ADD, 1'b0, 1'b0, 1'b1), ALL, '0, 64'd0, 1'b0);

    instruction = i_subi;
    cyc("subi_fetch", '0, ALL, '0, 64'd4, 1'b0);
    cyc("subi_exec", mk_cw(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, FS_SUB, 1'b1, 1'b0, 1'b1), no_sb, 64'd7, 64'd4, 1'b0);

    instruction = i_ldur;
    cyc("ldur_fetch", '0, ALL, '0, 64'd8, 1'b0);
    cyc("ldur_exec", cw_ld, ALL, 64'hFFFF_FFFF_FFFF_FFF8, 64'd8, 1'b0);
    cyc("ldur_memrd", cw_ld, ALL, 64'hFFFF_FFFF_FFFF_FFF8, 64'd8, 1'b0);
    cyc("ldur_wb", mk_cw(1'b0, 5'd2, 5'd0, 5'd9, 1'b1, FS_ADD, 1'b1, 1'b1, 1'b0), ALL,
        64'hFFFF_FFFF_FFFF_FFF8, 64'd8, 1'b0);

    instruction = i_stur;
    cyc("stur_fetch", '0, ALL, '0, 64'd12, 1'b0);
    cyc("stur_exec", mk_cw(1'b1, 5'd6, 5'd4, 5'd0, 1'b0, FS_ADD, 1'b1, 1'b0, 1'b0), ALL, 64'd16, 64'd12, 1'b0);

    instruction = i_bm2;
    cyc("bm2_fetch", '0, ALL, '0, 64'h10, 1'b0);
    cyc("bm2_exec", '0, ALL, '0, 64'h10, 1'b0);
    instruction = i_bp6;
    cyc("bp6_fetch", '0, ALL, '0, 64'h08, 1'b0);
    cyc("bp6_exec", '0, ALL, '0, 64'h08, 1'b0);

    instruction = i_cbz; status = 4'b0001;
    cyc("cbz_t_fetch", '0, ALL, '0, 64'h20, 1'b0);
    cyc("cbz_t_exec", cw_cbz, ALL, '0, 64'h20, 1'b0);
    status = 4'b0000; instruction = i_bm3;
    cyc("bm3_fetch", '0, ALL, '0, 64'h2C, 1'b0);
    cyc("bm3_exec", '0, ALL, '0, 64'h2C, 1'b0);
    instruction = i_cbz; status = 4'b1110;
    cyc("cbz_nt_fetch", '0, ALL, '0, 64'h20, 1'b0);
    cyc("cbz_nt_exec", cw_cbz, ALL, '0, 64'h20, 1'b0);

    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      instruction = (i % 2 == 0) ? 32'hFFFF_FFFF : i_add;
      cyc("stall", '0, ALL, '0, 64'h24, 1'b0);
    end

    run = 1'b1; instruction = 32'hFFFF_FFFF;
    cyc("undef_fetch", '0, ALL, '0, 64'h24, 1'b0);
    instruction = i_add;
    cyc("undef_exec", '0, ALL, '0, 64'h24, 1'b0);
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      instruction = (i % 3 == 0) ? i_ldur : i_add;
      cyc("halt", '0, ALL, '0, 64'h24, 1'b1);
    end

    #2 reset = 1'b1;
    #1 now_chk("halt_reset", '0, '0, 64'd0, 1'b0);
    @(posedge clock); #1 reset = 1'b0;

    run = 1'b1; instruction = i_ldur;
    cyc("ldur2_fetch", '0, ALL, '0, 64'd0, 1'b0);
    cyc("ldur2_exec", cw_ld, ALL, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b0);
    @(negedge clock);
    now_chk("ldur2_memrd", cw_ld, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b0);
    #2 reset = 1'b1;
    #1 now_chk("memrd_reset", '0, '0, 64'd0, 1'b0);
    @(posedge clock); #1 reset = 1'b0; run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc("post_reset", '0, ALL, '0, 64'd0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
